// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-coded byte packer: buffers variable-length codes in a FIFO,
// packs them MSB-first into bytes, stuffs 0x00 after 0xFF and pads the last
// partial byte of a frame with 1s when a flush is requested.
module jpeg_bit_packer #(
  parameter int FIFO_AW = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [5:0]         i_elen,
  input  logic [31:0]        i_edata,
  output logic [FIFO_AW:0]   o_free,
  input  logic               i_flush,
  output logic               o_flush_done,
  output logic               o_ovalid,
  output logic [7:0]         o_odata,
  input  logic               i_oready,
  output logic               o_err
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {RUN, STUFF, PAD, FDONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [37:0]         r_mem [DEPTH];
  logic [FIFO_AW:0]    r_wptr;
  logic [FIFO_AW:0]    r_rptr;
  logic [FIFO_AW:0]    r_free;
  logic [39:0]         r_buf;
  logic [5:0]          r_fill;
  logic                r_flushPend;
  logic                r_ovalid;
  logic [7:0]          r_odata;
  logic                r_flushDone;
  logic                r_err;

  logic                w_empty;
  logic                w_full;
  logic                w_lenOk;
  logic                w_push;
  logic                w_pop;
  logic [37:0]         w_head;
  logic [5:0]          w_headLen;
  logic [31:0]         w_headData;
  logic                w_accept;
  logic                w_stuffNeeded;
  logic                w_slotFree;
  logic                w_loadStuff;
  logic                w_loadData;
  logic                w_loadPad;
  logic                w_flushDoneNext;
  logic [39:0]         w_bufShift;
  logic [5:0]          w_fillShift;
  logic [39:0]         w_codeAligned;
  logic [39:0]         w_append;
  logic [7:0]          w_padByte;

  assign w_empty       = (r_wptr == r_rptr);
  assign w_full        = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                         (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_lenOk       = (i_elen != 6'd0) && (i_elen <= 6'd32);
  assign w_push        = w_lenOk && !w_full;
  assign w_head        = r_mem[r_rptr[FIFO_AW-1:0]];
  assign w_headLen     = w_head[37:32];
  assign w_headData    = w_head[31:0];
  assign w_accept      = r_ovalid && i_oready;
  assign w_stuffNeeded = w_accept && (r_odata == 8'hFF);
  assign w_slotFree    = !r_ovalid || w_accept;
  assign w_pop         = ((r_state == RUN) || (r_state == STUFF)) && !w_empty &&
                         (({1'b0, r_fill} + {1'b0, w_headLen}) <= 7'd40);

  // Shift out the presented byte first, then append the popped code right
  // behind the bits that remain; the code's MSB lands at bit 39-fill.
  assign w_bufShift    = w_loadData ? {r_buf[31:0], 8'h00} : r_buf;
  assign w_fillShift   = w_loadData ? (r_fill - 6'd8) : r_fill;
  assign w_codeAligned = {w_headData, 8'h00} << (6'd32 - w_headLen);
  assign w_append      = w_codeAligned >> w_fillShift;
  assign w_padByte     = r_buf[39:32] | (8'hFF >> r_fill);

  assign o_free       = r_free;
  assign o_flush_done = r_flushDone;
  assign o_ovalid     = r_ovalid;
  assign o_odata      = r_odata;
  assign o_err        = r_err;

  // FIFO storage; data bits above the code length are cleared on the way in
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wptr[FIFO_AW-1:0]] <= {i_elen, i_edata & (32'hFFFF_FFFF >> (6'd32 - i_elen))};
  end

  // FIFO pointers, free-entry count and sticky error flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_free <= DEPTH[FIFO_AW:0];
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_free <= r_free - 1'b1;
        2'b01:   r_free <= r_free + 1'b1;
        default: r_free <= r_free;
      endcase
      if ((i_elen > 6'd32) || ((i_elen != 6'd0) && w_full)) r_err <= 1'b1;
    end
  end

  // Left-aligned bit buffer: byte extraction, code append, and final padding
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (w_loadPad) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (w_pop) begin
      r_buf  <= w_bufShift | w_append;
      r_fill <= w_fillShift + w_headLen;
    end else begin
      r_buf  <= w_bufShift;
      r_fill <= w_fillShift;
    end
  end

  // Output byte holding register plus flush bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovalid    <= 1'b0;
      r_odata     <= 8'h00;
      r_flushDone <= 1'b0;
      r_flushPend <= 1'b0;
      r_state     <= RUN;
    end else begin
      r_state     <= w_next;
      r_flushDone <= w_flushDoneNext;
      if (i_flush)              r_flushPend <= 1'b1;
      else if (w_flushDoneNext) r_flushPend <= 1'b0;
      if (w_loadStuff) begin
        r_ovalid <= 1'b1;
        r_odata  <= 8'h00;
      end else if (w_loadData) begin
        r_ovalid <= 1'b1;
        r_odata  <= r_buf[39:32];
      end else if (w_loadPad) begin
        r_ovalid <= 1'b1;
        r_odata  <= w_padByte;
      end else if (w_accept) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  // Next state and byte-load decisions; an accepted 0xFF always wins so its
  // stuff byte follows immediately
  always_comb begin
    w_next          = r_state;
    w_loadStuff     = 1'b0;
    w_loadData      = 1'b0;
    w_loadPad       = 1'b0;
    w_flushDoneNext = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_stuffNeeded) begin
          w_loadStuff = 1'b1;
          w_next      = STUFF;
        end else if ((r_fill >= 6'd8) && w_slotFree) begin
          w_loadData = 1'b1;
        end else if (r_flushPend && w_empty && (r_fill < 6'd8)) begin
          w_next = PAD;
        end
      end
      STUFF: begin
        if (w_accept) w_next = RUN;
      end
      PAD: begin
        if (w_stuffNeeded) begin
          w_loadStuff = 1'b1;
          w_next      = STUFF;
        end else if (r_fill == 6'd0) begin
          w_next = FDONE;
        end else if (w_slotFree) begin
          w_loadPad = 1'b1;
        end
      end
      FDONE: begin
        if (w_stuffNeeded) begin
          w_loadStuff = 1'b1;
          w_next      = STUFF;
        end else if (w_slotFree) begin
          w_flushDoneNext = 1'b1;
          w_next          = RUN;
        end
      end
      default: w_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Scoreboard bench for jpeg_bit_packer: a bit-queue reference model predicts
// the byte stream and flush_done markers; a monitor checks what the DUT emits.
module tb_jpeg_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  elen = '0;
  logic [31:0] edata = '0;
  logic [7:0]  free;
  logic        flush = 1'b0;
  logic        flushDone;
  logic        ovalid;
  logic [7:0]  odata;
  logic        oready = 1'b0;
  logic        err;

  int total = 0;
  int bad = 0;
  bit bitQ[$];
  int expQ[$];
  int monExp;
  bit randReady = 1'b0;

  localparam int FLUSH_MARK = -1;

  jpeg_bit_packer #(.FIFO_AW(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_elen(elen), .i_edata(edata),
    .o_free(free), .i_flush(flush), .o_flush_done(flushDone),
    .o_ovalid(ovalid), .o_odata(odata), .i_oready(oready), .o_err(err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Monitor: every accepted byte and every flush_done pulse consumes one
  // scoreboard entry in order
  always @(negedge clk) begin
    if (!rst) begin
      if (ovalid && oready) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL byte: got %02h, required nothing", odata);
        end else begin
          monExp = expQ.pop_front();
          if (monExp != int'(odata)) begin
            bad++;
            $display("[TB] FAIL byte: got %02h, required %0d (-1 = flush_done)", odata, monExp);
          end
        end
      end
      if (flushDone) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL flush_done: got pulse, required nothing");
        end else begin
          monExp = expQ.pop_front();
          if (monExp != FLUSH_MARK) begin
            bad++;
            $display("[TB] FAIL flush_done: got pulse, required byte %02h", monExp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) oready = 1'($urandom_range(0, 1));
  endtask

  task automatic emitByte();
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) b[i] = bitQ.pop_front();
    expQ.push_back(int'(b));
    if (b == 8'hFF) expQ.push_back(0);
  endtask

  task automatic modelCode(input int len, input logic [31:0] data);
    for (int i = len - 1; i >= 0; i--) bitQ.push_back(data[i]);
    while (bitQ.size() >= 8) emitByte();
  endtask

  task automatic modelFlush();
    if (bitQ.size() > 0) begin
      while (bitQ.size() < 8) bitQ.push_back(1'b1);
      emitByte();
    end
    expQ.push_back(FLUSH_MARK);
  endtask

  task automatic applyStimulus(input int len, input logic [31:0] data, input bit toModel);
    elen  = 6'(len);
    edata = data;
    tick();
    elen  = '0;
    edata = $urandom;
    if (toModel && len >= 1 && len <= 32) modelCode(len, data);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    modelFlush();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
    checkOutput("drain_pending", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic midReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_ovalid", ovalid, 0);
    checkOutput("rst_odata", odata, 0);
    checkOutput("rst_flush_done", flushDone, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_free", free, 128);
    expQ.delete();
    bitQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  // Main stimulus sequence
  initial begin
    logic [31:0] d;
    int len;
    #1 rst = 1'b1;
    tick();
    tick();
    checkOutput("init_ovalid", ovalid, 0);
    checkOutput("init_free", free, 128);
    checkOutput("init_err", err, 0);
    rst = 1'b0;
    tick();

    // Directed cases
    oready = 1'b1;
    applyStimulus(8, 32'h0000_00A5, 1);
    waitDrain(50);
    checkOutput("free_after_a5", free, 128);
    applyStimulus(3, 32'hFFFF_FFF5, 1);
    applyStimulus(5, 32'h0000_0013, 1);
    waitDrain(50);
    applyStimulus(16, 32'h0000_FF12, 1);
    waitDrain(50);
    applyStimulus(4, 32'h0000_000A, 1);
    doFlush();
    waitDrain(50);
    doFlush();
    waitDrain(50);

    // Backpressure: one 32-bit code fits in the bit buffer, nine stay queued
    oready = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(32, 32'h1234_5678, 1);
    tick();
    tick();
    tick();
    checkOutput("free_backpressure", free, 119);
    oready = 1'b1;
    waitDrain(200);
    checkOutput("free_recovered", free, 128);

    // Randomized traffic paced by the free count, with random back-pressure
    randReady = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (free >= 8'd64 && $urandom_range(0, 3) != 0) begin
        len = $urandom_range(0, 32);
        d   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        applyStimulus(len, d, 1);
      end else begin
        tick();
      end
      if ($urandom_range(0, 99) == 0) begin
        doFlush();
        waitDrain(3000);
      end
    end
    doFlush();
    waitDrain(3000);
    randReady = 1'b0;
    oready = 1'b1;
    checkOutput("free_after_random", free, 128);
    checkOutput("err_before_badlen", err, 0);

    // Illegal length sets err and produces no output
    applyStimulus(40, $urandom, 0);
    tick();
    checkOutput("err_badlen", err, 1);
    waitDrain(20);
    midReset();

    // Overflow: first code sits in the bit buffer, 128 fill the FIFO, rest dropped
    oready = 1'b0;
    for (int i = 0; i < 131; i++) applyStimulus(32, $urandom, (i < 129));
    tick();
    tick();
    checkOutput("err_overflow", err, 1);
    checkOutput("free_full", free, 0);
    oready = 1'b1;
    waitDrain(2000);
    checkOutput("err_sticky", err, 1);
    checkOutput("free_after_overflow", free, 128);

    // Reset while bytes are still streaming out
    for (int i = 0; i < 10; i++) applyStimulus(32, $urandom, 1);
    tick();
    tick();
    midReset();
    applyStimulus(8, 32'h0000_00A5, 1);
    waitDrain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
